// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable dot-clock divider channels.
package clk_div_pkg;

  // Smallest usable divisor: one high cycle, one low cycle.
  localparam int unsigned DIV_MIN   = 2;
  // Widest divisor the helper functions operate on.
  localparam int unsigned MAX_DIV_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  // Divisors of 0 or 1 cannot form a clock, so they are promoted to 2.
  function automatic logic [MAX_DIV_W-1:0] clamp_div(input logic [MAX_DIV_W-1:0] v);
    return (v < DIV_MIN) ? DIV_MIN : v;
  endfunction

  // High-phase length; odd divisors give the extra cycle to the high phase.
  function automatic logic [MAX_DIV_W-1:0] high_len(input logic [MAX_DIV_W-1:0] d);
    return (d >> 1) + {{(MAX_DIV_W-1){1'b0}}, d[0]};
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: IDLE/RUN control, period counter and pending divisor.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ch_en,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  output logic             div_out,
  output logic             tick,
  output logic             ch_active,
  output logic             div_pend
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(clamp_div(32'(DEFAULT_DIV)));

  ch_state_e        state_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] pend_div_q;
  logic             pend_q;
  logic             div_out_q;
  logic             tick_q;

  logic [DIV_W-1:0] load_val_d;
  logic [DIV_W-1:0] high_len_d;
  logic [DIV_W-1:0] cnt_d;
  logic             wrap_d;

  // Divisor capture is always clamped, so div_q never holds a value below 2.
  assign load_val_d = DIV_W'(clamp_div(32'(div_value)));
  assign high_len_d = DIV_W'(high_len(32'(div_q)));
  assign wrap_d     = (cnt_q == (div_q - DIV_W'(1)));
  assign cnt_d      = wrap_d ? '0 : (cnt_q + DIV_W'(1));

  // Channel state machine; outputs are registered alongside the counter so
  // div_out/tick are aligned with the phase held in cnt_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= RST_DIV;
      pend_div_q <= RST_DIV;
      pend_q     <= 1'b0;
      div_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q     <= '0;
          pend_q    <= 1'b0;
          div_out_q <= 1'b0;
          tick_q    <= 1'b0;
          // No period is in flight, so a new divisor can take effect at once.
          if (div_load) begin
            div_q <= load_val_d;
          end
          if (ch_en) begin
            state_q   <= RUN;
            div_out_q <= 1'b1;
            tick_q    <= 1'b1;
          end
        end
        RUN: begin
          if (wrap_d) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
            // A load coinciding with the wrap is newer than anything pending.
            if (div_load) begin
              div_q <= load_val_d;
            end else if (pend_q) begin
              div_q <= pend_div_q;
            end
            if (ch_en) begin
              div_out_q <= 1'b1;
              tick_q    <= 1'b1;
            end else begin
              state_q   <= IDLE;
              div_out_q <= 1'b0;
              tick_q    <= 1'b0;
            end
          end else begin
            cnt_q     <= cnt_d;
            div_out_q <= (cnt_d < high_len_d);
            tick_q    <= 1'b0;
            // Hold the new divisor until the current period has finished.
            if (div_load) begin
              pend_div_q <= load_val_d;
              pend_q     <= 1'b1;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          div_out_q <= 1'b0;
          tick_q    <= 1'b0;
        end
      endcase
    end
  end

  assign div_out   = div_out_q;
  assign tick      = tick_q;
  assign ch_active = (state_q == RUN);
  assign div_pend  = pend_q;

endmodule

// File: rtl/dot_clock_div.sv
// Multi-channel programmable dot-clock divider; one independent channel per bit.
module dot_clock_div
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic [NUM_CH*DIV_W-1:0] div_value,
  output logic [NUM_CH-1:0]       div_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       ch_active,
  output logic [NUM_CH-1:0]       div_pend
);

  // Channels share nothing but the clock and reset; no phase alignment.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      clk_div_chan #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_en     (ch_en[gi]),
        .div_load  (div_load[gi]),
        .div_value (div_value[gi*DIV_W +: DIV_W]),
        .div_out   (div_out[gi]),
        .tick      (tick[gi]),
        .ch_active (ch_active[gi]),
        .div_pend  (div_pend[gi])
      );
    end
  endgenerate

endmodule
